// File: rtl/dcache_flush_engine.sv
// Write-back flush walker for the direct-mapped dcache: scans every tag/data SRAM line,
// writes valid+dirty lines to Data Memory and clears their dirty bits.
module dcache_flush_engine #(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned TAG_W     = 24,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_req_i,
  output logic                flush_busy_o,
  output logic                flush_done_o,
  output logic [IDX_W:0]      lines_written_o,
  output logic [IDX_W-1:0]    sram_idx_o,
  input  logic [TAG_W-1:0]    sram_tag_i,
  input  logic [LINE_W-1:0]   sram_data_i,
  output logic                sram_tag_we_o,
  output logic [TAG_W-1:0]    sram_tag_o,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  input  logic                mem_ack_i
);

  localparam int unsigned TAGF_W = TAG_W - 2;
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W  = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_CLEAN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    lines_q, lines_d;
  logic [TAGF_W-1:0]   tag_q, tag_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                en_q, en_d;
  logic                tag_we_q, tag_we_d;
  logic [TAG_W-1:0]    sram_tag_q, sram_tag_d;
  logic                last_line;
  logic                line_dirty;

  assign last_line  = (idx_q == IDX_W'(NUM_LINES - 1));
  assign line_dirty = sram_tag_i[TAG_W-1] & sram_tag_i[TAG_W-2];

  // Next state, walk index, counters and captured line
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lines_d = lines_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush_req_i) begin
          idx_d   = '0;
          lines_d = '0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_CHECK;
      S_CHECK: begin
        if (line_dirty) begin
          tag_d   = sram_tag_i[TAGF_W-1:0];
          data_d  = sram_data_i;
          addr_d  = ADDR_W'({sram_tag_i[TAGF_W-1:0], idx_q, {OFF_W{1'b0}}});
          state_d = S_WRITE;
        end else if (last_line) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (mem_ack_i) state_d = S_CLEAN;
      end
      S_CLEAN: begin
        lines_d = lines_q + CNT_W'(1);
        if (last_line) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    en_d       = (state_d == S_WRITE);
    tag_we_d   = (state_d == S_CLEAN);
    sram_tag_d = '0;
    if (tag_we_d) sram_tag_d = {1'b1, 1'b0, tag_d};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      lines_q    <= '0;
      tag_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      tag_we_q   <= 1'b0;
      sram_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lines_q    <= lines_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      en_q       <= en_d;
      tag_we_q   <= tag_we_d;
      sram_tag_q <= sram_tag_d;
    end
  end

  assign flush_busy_o    = busy_q;
  assign flush_done_o    = done_q;
  assign lines_written_o = lines_q;
  assign sram_idx_o      = idx_q;
  assign sram_tag_we_o   = tag_we_q;
  assign sram_tag_o      = sram_tag_q;
  assign mem_enable_o    = en_q;
  assign mem_write_o     = en_q;
  assign mem_addr_o      = addr_q;
  assign mem_data_o      = data_q;

endmodule

// File: tb/tb_dcache_flush_engine.sv
// Scoreboard bench for dcache_flush_engine: SRAM and memory models, expected writes queued
// by the stimulus, a negedge monitor pops and compares.
module tb_dcache_flush_engine;

  localparam int unsigned NUM_LINES = 32;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned TAG_W     = 24;
  localparam int unsigned LINE_W    = 256;
  localparam int unsigned ADDR_W    = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } wr_t;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               flush_req_i;
  logic               flush_busy_o;
  logic               flush_done_o;
  logic [IDX_W:0]     lines_written_o;
  logic [IDX_W-1:0]   sram_idx_o;
  logic [TAG_W-1:0]   sram_tag_i;
  logic [LINE_W-1:0]  sram_data_i;
  logic               sram_tag_we_o;
  logic [TAG_W-1:0]   sram_tag_o;
  logic               mem_enable_o;
  logic               mem_write_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [LINE_W-1:0]  mem_data_o;
  logic               mem_ack_i;

  logic [TAG_W-1:0]   tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]  data_mem [NUM_LINES];

  wr_t                     exp_wr[$];
  logic [IDX_W+TAG_W-1:0]  exp_tw[$];

  int errors = 0;
  int checks = 0;
  int ack_lat = 2;
  bit stray = 1'b0;
  int busy_run = 0;
  int last_busy = 0;
  int done_cnt = 0;
  int wr_seen = 0;

  dcache_flush_engine dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_req_i     (flush_req_i),
    .flush_busy_o    (flush_busy_o),
    .flush_done_o    (flush_done_o),
    .lines_written_o (lines_written_o),
    .sram_idx_o      (sram_idx_o),
    .sram_tag_i      (sram_tag_i),
    .sram_data_i     (sram_data_i),
    .sram_tag_we_o   (sram_tag_we_o),
    .sram_tag_o      (sram_tag_o),
    .mem_enable_o    (mem_enable_o),
    .mem_write_o     (mem_write_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_o      (mem_data_o),
    .mem_ack_i       (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Synchronous-read SRAM: index captured in one cycle, data presented the next
  initial begin
    logic [IDX_W-1:0] r_idx;
    logic             r_we;
    logic [TAG_W-1:0] r_tag;
    sram_tag_i  = '0;
    sram_data_i = '0;
    forever begin
      @(negedge clk_i);
      r_idx = sram_idx_o;
      r_we  = sram_tag_we_o;
      r_tag = sram_tag_o;
      @(posedge clk_i);
      #1;
      sram_tag_i  = tag_mem[r_idx];
      sram_data_i = data_mem[r_idx];
      if (r_we) tag_mem[r_idx] = r_tag;
    end
  end

  // Memory responder: ack in the ack_lat-th cycle of a request; optional stray acks when idle
  initial begin
    int wcnt;
    wcnt      = 0;
    mem_ack_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (mem_enable_o) begin
        wcnt++;
        mem_ack_i = (wcnt == ack_lat);
      end else begin
        wcnt      = 0;
        mem_ack_i = stray;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    wr_t e;
    bit  prev_ack;
    logic [IDX_W+TAG_W-1:0] t;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        busy_run = 0;
        prev_ack = 1'b0;
      end else begin
        if (prev_ack) chk("enable_after_ack", LINE_W'(mem_enable_o), LINE_W'(0));
        prev_ack = mem_enable_o && mem_ack_i;
        if (mem_enable_o) chk("write_eq_enable", LINE_W'(mem_write_o), LINE_W'(1));
        if (mem_enable_o && mem_ack_i) begin
          wr_seen++;
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", LINE_W'(1), LINE_W'(0));
          end else begin
            e = exp_wr.pop_front();
            chk("mem_addr", LINE_W'(mem_addr_o), LINE_W'(e.addr));
            chk("mem_data", mem_data_o, e.data);
          end
        end
        if (sram_tag_we_o) begin
          if (exp_tw.size() == 0) begin
            chk("unexpected_tag_write", LINE_W'(1), LINE_W'(0));
          end else begin
            t = exp_tw.pop_front();
            chk("tag_write", LINE_W'({sram_idx_o, sram_tag_o}), LINE_W'(t));
          end
        end
        busy_run = flush_busy_o ? busy_run + 1 : 0;
        if (flush_done_o) begin
          done_cnt++;
          last_busy = busy_run;
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < NUM_LINES; i++) begin
      tag_mem[i]  = '0;
      data_mem[i] = '0;
    end
  endtask

  task automatic set_line(input int idx, input logic [TAG_W-1:0] tag, input logic [LINE_W-1:0] data,
                          input logic [ADDR_W-1:0] exp_addr);
    tag_mem[idx]  = tag;
    data_mem[idx] = data;
    exp_wr.push_back('{addr: exp_addr, data: data});
    exp_tw.push_back({IDX_W'(idx), 2'b10, tag[21:0]});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!flush_done_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (!flush_done_o) chk("done_timeout", LINE_W'(0), LINE_W'(1));
    @(negedge clk_i);
  endtask

  task automatic run_flush(input int lat);
    ack_lat = lat;
    @(negedge clk_i);
    flush_req_i = 1'b1;
    @(negedge clk_i);
    flush_req_i = 1'b0;
    wait_done();
  endtask

  task automatic post_flush(input string name, input int busy, input int lines,
                            input int d0, input int w0, input int wcount);
    chk({name, "_busy_cycles"}, LINE_W'(last_busy), LINE_W'(busy));
    chk({name, "_lines"}, LINE_W'(lines_written_o), LINE_W'(lines));
    chk({name, "_done_pulses"}, LINE_W'(done_cnt - d0), LINE_W'(1));
    chk({name, "_writes"}, LINE_W'(wr_seen - w0), LINE_W'(wcount));
    chk({name, "_exp_wr_left"}, LINE_W'(exp_wr.size()), LINE_W'(0));
    chk({name, "_exp_tw_left"}, LINE_W'(exp_tw.size()), LINE_W'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int w0;
    int cnt;
    rst_i       = 1'b1;
    flush_req_i = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk_i);
    chk("rst_busy",   LINE_W'(flush_busy_o),    LINE_W'(0));
    chk("rst_done",   LINE_W'(flush_done_o),    LINE_W'(0));
    chk("rst_lines",  LINE_W'(lines_written_o), LINE_W'(0));
    chk("rst_idx",    LINE_W'(sram_idx_o),      LINE_W'(0));
    chk("rst_tag_we", LINE_W'(sram_tag_we_o),   LINE_W'(0));
    chk("rst_enable", LINE_W'(mem_enable_o),    LINE_W'(0));
    chk("rst_write",  LINE_W'(mem_write_o),     LINE_W'(0));
    chk("rst_addr",   LINE_W'(mem_addr_o),      LINE_W'(0));
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // 1: all lines clean
    d0 = done_cnt; w0 = wr_seen;
    run_flush(2);
    post_flush("t1", 65, 0, d0, w0, 0);

    // 2: single dirty line at idx 3, W=2
    clear_mem();
    set_line(3, 24'hC00012, 256'hA5, 32'h0000_4860);
    d0 = done_cnt; w0 = wr_seen;
    run_flush(2);
    post_flush("t2", 68, 1, d0, w0, 1);
    chk("t2_tag3_clean", LINE_W'(tag_mem[3]), LINE_W'(24'h800012));

    // 3: valid-only and dirty-only lines are left alone
    clear_mem();
    tag_mem[0] = 24'h800000;
    tag_mem[1] = 24'h400000;
    d0 = done_cnt; w0 = wr_seen;
    run_flush(2);
    post_flush("t3", 65, 0, d0, w0, 0);
    chk("t3_tag1_kept", LINE_W'(tag_mem[1]), LINE_W'(24'h400000));

    // 4: every line dirty, W=10
    clear_mem();
    for (int i = 0; i < NUM_LINES; i++)
      set_line(i, 24'hC00000 | TAG_W'(i + 16), LINE_W'(i * 7 + 1),
               ADDR_W'(((i + 16) << 10) | (i << 5)));
    d0 = done_cnt; w0 = wr_seen;
    run_flush(10);
    post_flush("t4", 64 + 32 * 11 + 1, 32, d0, w0, 32);

    // 5: reset in the 4th WRITE cycle, then restart from idx 0
    clear_mem();
    set_line(0, 24'hC00001, 256'h11, 32'h0000_0400);
    set_line(2, 24'hC00002, 256'h22, 32'h0000_0840);
    ack_lat = 20;
    @(negedge clk_i);
    flush_req_i = 1'b1;
    @(negedge clk_i);
    flush_req_i = 1'b0;
    cnt = 0;
    for (int n = 0; n < 200 && cnt < 4; n++) begin
      @(posedge clk_i);
      #1;
      if (mem_enable_o) cnt++;
    end
    chk("t5_reached_write4", LINE_W'(cnt), LINE_W'(4));
    #1;
    rst_i = 1'b1;
    #1;
    chk("t5_async_enable", LINE_W'(mem_enable_o), LINE_W'(0));
    chk("t5_async_busy",   LINE_W'(flush_busy_o), LINE_W'(0));
    chk("t5_async_idx",    LINE_W'(sram_idx_o),   LINE_W'(0));
    exp_wr.delete();
    exp_tw.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("t5_idle_after_rst", LINE_W'(flush_busy_o), LINE_W'(0));
    set_line(0, 24'hC00001, 256'h11, 32'h0000_0400);
    set_line(2, 24'hC00002, 256'h22, 32'h0000_0840);
    d0 = done_cnt; w0 = wr_seen;
    run_flush(3);
    post_flush("t5", 64 + 2 * 4 + 1, 2, d0, w0, 2);

    // 6: request held high through a flush, stray acks outside WRITE
    clear_mem();
    set_line(5, 24'hC00055, 256'h5555, 32'h0001_54A0);
    ack_lat = 3;
    stray   = 1'b1;
    d0 = done_cnt; w0 = wr_seen;
    @(negedge clk_i);
    flush_req_i = 1'b1;
    @(negedge clk_i);
    wait_done();
    chk("t6_idle_gap",     LINE_W'(flush_busy_o), LINE_W'(0));
    chk("t6_first_busy",   LINE_W'(last_busy),    LINE_W'(69));
    chk("t6_first_lines",  LINE_W'(lines_written_o), LINE_W'(1));
    @(negedge clk_i);
    chk("t6_second_start", LINE_W'(flush_busy_o), LINE_W'(1));
    flush_req_i = 1'b0;
    wait_done();
    stray = 1'b0;
    chk("t6_second_busy",  LINE_W'(last_busy),       LINE_W'(65));
    chk("t6_second_lines", LINE_W'(lines_written_o), LINE_W'(0));
    chk("t6_done_pulses",  LINE_W'(done_cnt - d0),   LINE_W'(2));
    chk("t6_writes",       LINE_W'(wr_seen - w0),    LINE_W'(1));
    chk("t6_exp_wr_left",  LINE_W'(exp_wr.size()),   LINE_W'(0));
    repeat (3) @(negedge clk_i);
    chk("t6_no_third",     LINE_W'(flush_busy_o),    LINE_W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
